// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// issued by the control unit and the sequencer state encoding.
package sm_muldiv_pkg;

    localparam logic [2:0] MD_MULTU = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_DIVU  = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_RUN  = 2'd1,
        MDS_FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/sm_muldiv_neg.sv
// Conditional two's-complement negate; used both to take operand magnitudes
// and to restore the sign of results.
module sm_muldiv_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] val_o
);

    assign val_o = neg_i ? ((~val_i) + WIDTH'(1)) : val_i;

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MIPS multiply/divide unit with HI/LO registers: shift-add multiply,
// restoring divide, one bit per cycle, sign fix-up in a final cycle.
module sm_muldiv
    import sm_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       state_dbg
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    md_state_t          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic               is_div_q, is_div_d, neg_q, neg_d;
    logic               sign_a_q, sign_a_d, b_zero_q, b_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, div_zero_q, div_zero_d;

    logic               signed_op, sign_a_in, sign_b_in, div_ge;
    logic [WIDTH-1:0]   abs_a, abs_b, div_diff, quo, rem, rem_src;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    assign signed_op = SIGNED_EN && ((op == MD_MULT) || (op == MD_DIV));
    assign sign_a_in = signed_op & srcA[WIDTH-1];
    assign sign_b_in = signed_op & srcB[WIDTH-1];

    sm_muldiv_neg #(.WIDTH(WIDTH)) u_abs_a (.val_i(srcA), .neg_i(sign_a_in), .val_o(abs_a));
    sm_muldiv_neg #(.WIDTH(WIDTH)) u_abs_b (.val_i(srcB), .neg_i(sign_b_in), .val_o(abs_b));

    // Multiply: acc = {partial product, unconsumed multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting out / quotient bits shifting in}.
    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b_q};
    assign div_diff  = div_shift[WIDTH-1:0] - mag_b_q;
    assign div_next  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    // Divide by zero reports the original dividend in HI: magnitude re-signed by sign(A).
    assign rem_src = b_zero_q ? mag_a_q : acc_q[2*WIDTH-1:WIDTH];

    sm_muldiv_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.val_i(acc_q), .neg_i(neg_q), .val_o(prod));
    sm_muldiv_neg #(.WIDTH(WIDTH)) u_fix_quo (.val_i(acc_q[WIDTH-1:0]), .neg_i(neg_q), .val_o(quo));
    sm_muldiv_neg #(.WIDTH(WIDTH)) u_fix_rem (.val_i(rem_src), .neg_i(sign_a_q), .val_o(rem));

    // Handshake: start is sampled only while busy=0 (flush takes precedence);
    // busy stays high through RUN and FIX; done pulses one cycle with the new HI/LO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        sign_a_d   = sign_a_q;
        b_zero_d   = b_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        case (state_q)
            MDS_IDLE: begin
                if (start && !flush) begin
                    if (op <= MD_DIV) begin
                        state_d    = MDS_RUN;
                        cnt_d      = '0;
                        div_zero_d = 1'b0;
                        is_div_d   = op[1];
                        neg_d      = sign_a_in ^ sign_b_in;
                        sign_a_d   = sign_a_in;
                        b_zero_d   = (srcB == '0);
                        mag_a_d    = abs_a;
                        mag_b_d    = abs_b;
                        acc_d      = op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    end else if (op == MD_MTHI) begin
                        hi_d = srcA;
                    end else if (op == MD_MTLO) begin
                        lo_d = srcA;
                    end
                end
            end
            MDS_RUN: begin
                if (flush) begin
                    state_d = MDS_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = MDS_FIX;
                    end
                end
            end
            MDS_FIX: begin
                state_d = MDS_IDLE;
                if (!flush) begin
                    done_d     = 1'b1;
                    div_zero_d = is_div_q & b_zero_q;
                    if (is_div_q) begin
                        hi_d = rem;
                        lo_d = b_zero_q ? '1 : quo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = MDS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= MDS_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            sign_a_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            sign_a_q   <= sign_a_d;
            b_zero_q   <= b_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy      = (state_q != MDS_IDLE);
    assign done      = done_q;
    assign divZero   = div_zero_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sm_muldiv.sv
// Bench for sm_muldiv: signed and unsigned 32-bit instances share stimulus,
// an 8-bit instance runs separately; results come from an arithmetic model.
module tb_sm_muldiv;
    import sm_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush;
    logic [2:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy_s, done_s, dz_s, busy_u, done_u, dz_u;
    logic [31:0] hi_s, lo_s, hi_u, lo_u;
    logic [1:0]  st_s, st_u, st8;
    logic        start8, flush8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic        busy8, done8, dz8;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [31:0] ehi_s, elo_s, ehi_u, elo_u;
    logic [7:0]  ehi8, elo8;

    always #5 clk = ~clk;

    sm_muldiv #(.WIDTH(32), .SIGNED_EN(1'b1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .busy(busy_s), .done(done_s), .divZero(dz_s), .hi(hi_s),
        .lo(lo_s), .state_dbg(st_s));

    sm_muldiv #(.WIDTH(32), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
        .flush(flush), .busy(busy_u), .done(done_u), .divZero(dz_u), .hi(hi_u),
        .lo(lo_u), .state_dbg(st_u));

    sm_muldiv #(.WIDTH(8), .SIGNED_EN(1'b1)) dut_8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .srcA(a8), .srcB(b8),
        .flush(flush8), .busy(busy8), .done(done8), .divZero(dz8), .hi(hi8),
        .lo(lo8), .state_dbg(st8));

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input bit sen, input logic [2:0] o,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output logic edz);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb, q, r;
        bit          sgn;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = longint'(ua << (64 - w)) >>> (64 - w);
        sb   = longint'(ub << (64 - w)) >>> (64 - w);
        sgn  = sen && (o == MD_MULT || o == MD_DIV);
        edz  = 1'b0;
        ehi  = '0;
        elo  = '0;
        if (o == MD_MULTU || o == MD_MULT) begin
            if (sgn) p = sa * sb;
            else p = ua * ub;
            elo = 32'(p & mask);
            ehi = 32'((p >> w) & mask);
        end else if (ub == 64'd0) begin
            elo = 32'(mask);
            ehi = 32'(ua);
            edz = 1'b1;
        end else if (sgn) begin
            q   = sa / sb;
            r   = sa % sb;
            p   = q;
            elo = 32'(p & mask);
            p   = r;
            ehi = 32'(p & mask);
        end else begin
            elo = 32'(ua / ub);
            ehi = 32'(ua % ub);
        end
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v, m;
        m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000 >> (32 - w);
            3:       v = $urandom_range(1, 9);
            default: v = $urandom;
        endcase
        return v & m;
    endfunction

    task automatic do_op32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string tag, input int poke);
        logic [31:0] nh_s, nl_s, nh_u, nl_u;
        logic        nd_s, nd_u;
        int          lat;
        bit          busy_ok, hold_ok;
        model(32, 1'b1, o, a, b, nh_s, nl_s, nd_s);
        model(32, 1'b0, o, a, b, nh_u, nl_u, nd_u);
        start = 1'b1; op = o; srcA = a; srcB = b;
        tick();
        start = 1'b0;
        lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!done_s && lat < 64) begin
            if (!busy_s || !busy_u || done_u || dz_s || dz_u) busy_ok = 1'b0;
            if (hi_s !== ehi_s || lo_s !== elo_s || hi_u !== ehi_u || lo_u !== elo_u) hold_ok = 1'b0;
            if (poke >= 0 && lat == poke) begin
                start = 1'b1; op = MD_MTLO; srcA = $urandom;
            end else if (poke >= 0 && lat == poke + 1) begin
                start = 1'b1; op = MD_MULTU; srcA = $urandom; srcB = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'd33);
        chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, ".hilo_hold"}, 64'(hold_ok), 64'd1);
        chk({tag, ".busy_end"}, {62'd0, busy_s, busy_u}, 64'd0);
        chk({tag, ".done_u"}, 64'(done_u), 64'd1);
        ehi_s = nh_s; elo_s = nl_s; ehi_u = nh_u; elo_u = nl_u;
        chk({tag, ".s.hilo"}, {hi_s, lo_s}, {nh_s, nl_s});
        chk({tag, ".s.dz"}, 64'(dz_s), 64'(nd_s));
        chk({tag, ".u.hilo"}, {hi_u, lo_u}, {nh_u, nl_u});
        chk({tag, ".u.dz"}, 64'(dz_u), 64'(nd_u));
        tick();
        chk({tag, ".done_pulse"}, {62'd0, done_s, done_u}, 64'd0);
    endtask

    task automatic do_mt32(input logic [2:0] o, input logic [31:0] a, input bit fl, input string tag);
        start = 1'b1; op = o; srcA = a; flush = fl;
        tick();
        start = 1'b0; flush = 1'b0;
        if (!fl && o == MD_MTHI) begin ehi_s = a; ehi_u = a; end
        if (!fl && o == MD_MTLO) begin elo_s = a; elo_u = a; end
        chk({tag, ".idle"}, {60'd0, busy_s, busy_u, done_s, done_u}, 64'd0);
        chk({tag, ".s.hilo"}, {hi_s, lo_s}, {ehi_s, elo_s});
        chk({tag, ".u.hilo"}, {hi_u, lo_u}, {ehi_u, elo_u});
    endtask

    task automatic do_op8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [31:0] nh, nl;
        logic        nd;
        int          lat;
        bit          busy_ok;
        model(8, 1'b1, o, {24'd0, a}, {24'd0, b}, nh, nl, nd);
        start8 = 1'b1; op8 = o; a8 = a; b8 = b;
        tick();
        start8 = 1'b0;
        lat = 0; busy_ok = 1'b1;
        while (!done8 && lat < 64) begin
            if (!busy8 || hi8 !== ehi8 || lo8 !== elo8) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'd9);
        chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, ".busy_end"}, 64'(busy8), 64'd0);
        ehi8 = nh[7:0]; elo8 = nl[7:0];
        chk({tag, ".hilo"}, {48'd0, hi8, lo8}, {48'd0, nh[7:0], nl[7:0]});
        chk({tag, ".dz"}, 64'(dz8), 64'(nd));
        tick();
        chk({tag, ".done_pulse"}, 64'(done8), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;
        logic [2:0] ro;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; srcA = '0; srcB = '0;
        start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        ehi_s = '0; elo_s = '0; ehi_u = '0; elo_u = '0; ehi8 = '0; elo8 = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset.s", {29'd0, busy_s, done_s, dz_s, hi_s | lo_s}, 64'd0);
        chk("reset.u", {29'd0, busy_u, done_u, dz_u, hi_u | lo_u}, 64'd0);
        chk("reset.8", {45'd0, busy8, done8, dz8, hi8, lo8}, 64'd0);

        do_op32(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1);
        chk("multu_max.const", {hi_s, lo_s}, 64'hFFFF_FFFE_0000_0001);
        do_op32(MD_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", -1);
        chk("mult_neg3x7.const_s", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mult_neg3x7.const_u", {hi_u, lo_u}, 64'h0000_0006_FFFF_FFEB);
        do_op32(MD_DIVU, 32'd100, 32'd7, "divu_100_7", -1);
        chk("divu_100_7.const", {hi_s, lo_s}, {32'd2, 32'd14});
        do_op32(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", -1);
        chk("div_neg7_2.const", {hi_s, lo_s}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op32(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", -1);
        chk("div_min_m1.const", {hi_s, lo_s}, 64'h0000_0000_8000_0000);
        do_op32(MD_DIVU, 32'd5, 32'd0, "divu_by0", -1);
        chk("divu_by0.const", {31'd0, dz_s, hi_s}, {31'd0, 1'b1, 32'd5});
        do_op32(MD_MULTU, 32'd2, 32'd3, "multu_2x3", -1);
        do_op32(MD_DIV, 32'hFFFF_FFF0, 32'd0, "div_neg_by0", -1);

        do_mt32(MD_MTHI, 32'h0000_1234, 1'b0, "mthi");
        do_op32(MD_DIVU, 32'd9, 32'd4, "divu_9_4", -1);
        do_mt32(MD_MTLO, 32'hCAFE_F00D, 1'b0, "mtlo");
        do_op32(MD_MULTU, 32'd12345, 32'd678, "poke_run", 5);
        do_mt32(3'd6, 32'hDEAD_BEEF, 1'b0, "unknown_op");
        do_mt32(MD_MTHI, 32'hBAD0_BAD0, 1'b1, "flush_vs_mthi");

        // Abort a divide partway through.
        start = 1'b1; op = MD_DIVU; srcA = 32'd1000; srcB = 32'd3;
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.idle", {60'd0, busy_s, busy_u, done_s, done_u}, 64'd0);
        chk("flush.s.hilo", {hi_s, lo_s}, {ehi_s, elo_s});
        chk("flush.u.hilo", {hi_u, lo_u}, {ehi_u, elo_u});
        seen_done = 1'b0;
        repeat (40) begin
            tick();
            if (done_s || done_u || busy_s || busy_u) seen_done = 1'b1;
        end
        chk("flush.no_done", 64'(seen_done), 64'd0);

        do_op8(MD_MULTU, 8'hFF, 8'hFF, "w8_multu_max");
        chk("w8_multu_max.const", {48'd0, hi8, lo8}, 64'h0000_0000_0000_FE01);
        do_op8(MD_DIV, 8'h80, 8'hFF, "w8_div_min_m1");
        do_op8(MD_MULT, 8'hF9, 8'h05, "w8_mult_neg");

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 5));
            if (ro >= MD_MTHI) do_mt32(ro, $urandom, 1'b0, $sformatf("rnd32_%0d", i));
            else do_op32(ro, pick(32), pick(32), $sformatf("rnd32_%0d", i), -1);
        end
        for (int i = 0; i < 12; i++) begin
            do_op8(3'($urandom_range(0, 3)), 8'(pick(8)), 8'(pick(8)), $sformatf("rnd8_%0d", i));
        end

        // Reset in the middle of a signed divide.
        start = 1'b1; op = MD_DIV; srcA = 32'hFFFF_FF9C; srcB = 32'd7;
        tick();
        start = 1'b0;
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ehi_s = '0; elo_s = '0; ehi_u = '0; elo_u = '0; ehi8 = '0; elo8 = '0;
        chk("rst_mid.s", {29'd0, busy_s, done_s, dz_s, hi_s | lo_s}, 64'd0);
        chk("rst_mid.u", {29'd0, busy_u, done_u, dz_u, hi_u | lo_u}, 64'd0);
        chk("rst_mid.8", {45'd0, busy8, done8, dz8, hi8, lo8}, 64'd0);
        do_op32(MD_MULT, 32'h8000_0000, 32'h8000_0000, "after_rst", -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
